// File: rtl/config_loader_pkg.sv
// Shared FSM state type and CRC constants for the configuration chain loader.
// The readback CRC is only built when CFG_READBACK_CRC_EN is defined.
package config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT (poly 0x1021, MSB first, no reflection, no final XOR).
// Used by config_chain_loader only when CFG_READBACK_CRC_EN is defined.
module crc16_serial
    import config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[15] ^ bit_in;

    // clr takes priority so a new load always starts from the seed value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Head-of-chain serial configuration loader: shifts total_bits bits, MSB first, onto the chain.
// Define CFG_READBACK_CRC_EN to build a CRC over the bits returning on cfg_tail.
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_bits,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_bit,
    output logic              cfg_en,
    input  logic              cfg_tail,
    output logic              busy,
    output logic              done,
    output logic [15:0]       readback_crc
);

    localparam int WL_W = $clog2(WORD_W + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  rem_dec;
    logic [WL_W-1:0]   word_left;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] buf_data;
    logic              buf_full;
    logic              more_words;
    logic              last_bit;
    logic              load_buf;
    logic              load_direct;
    logic              kill;

    function automatic logic [WL_W-1:0] word_len(input logic [CNT_W-1:0] bits);
        if (bits >= CNT_W'(WORD_W)) return WL_W'(WORD_W);
        return WL_W'(bits);
    endfunction

    assign rem_dec    = remaining - CNT_W'(1);
    assign more_words = remaining > CNT_W'(word_left);
    assign last_bit   = (word_left == WL_W'(1));
    assign kill       = abort && (state != IDLE);

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On the last bit of a word the next word comes from the buffer, or straight
    // from the handshake if it lands in that same cycle, so the stream stays gap-free.
    always_comb begin
        state_next  = state;
        s_ready     = 1'b0;
        cfg_en      = 1'b0;
        cfg_bit     = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        load_buf    = 1'b0;
        load_direct = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (total_bits == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                s_ready = 1'b1;
                if (s_valid) state_next = SHIFT;
            end
            SHIFT: begin
                cfg_en  = 1'b1;
                cfg_bit = shreg[WORD_W-1];
                s_ready = !buf_full && more_words;
                if (last_bit) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next = DONE;
                    end else if (buf_full) begin
                        load_buf = 1'b1;
                    end else if (s_valid) begin
                        load_direct = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                done       = !abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            remaining <= '0;
            word_left <= '0;
            shreg     <= '0;
            buf_data  <= '0;
            buf_full  <= 1'b0;
        end else if (kill) begin
            buf_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) remaining <= total_bits;
                end
                FETCH: begin
                    if (s_valid) begin
                        shreg     <= s_data;
                        word_left <= word_len(remaining);
                    end
                end
                SHIFT: begin
                    remaining <= rem_dec;
                    word_left <= word_left - WL_W'(1);
                    shreg     <= {shreg[WORD_W-2:0], 1'b0};
                    if (load_buf) begin
                        shreg     <= buf_data;
                        buf_full  <= 1'b0;
                        word_left <= word_len(rem_dec);
                    end else if (load_direct) begin
                        shreg     <= s_data;
                        word_left <= word_len(rem_dec);
                    end else if (s_valid && s_ready) begin
                        buf_data <= s_data;
                        buf_full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CFG_READBACK_CRC_EN
    crc16_serial u_crc (
        .clk    (Config_Clock),
        .rst_n  (Config_Reset),
        .clr    ((state == IDLE) && start),
        .en     (cfg_en),
        .bit_in (cfg_tail),
        .crc    (readback_crc)
    );
`else
    logic unused_tail;
    assign unused_tail  = cfg_tail;
    assign readback_crc = 16'h0000;
`endif

endmodule
